cic_interp_sched: RTL and testbench

//  TDM scheduler for a shared 4x CIC interpolator. Buffers NCH independent 16-bit sample streams
//  and emits one sample per clk_7p68MHz cycle in a fixed round-robin slot order.

---
 rtl/cic_sched_pkg.sv | 19 +
 rtl/cic_sched_fifo2.sv | 49 ++++
 rtl/cic_interp_sched.sv | 176 +++++++++++++++++
 tb/tb_cic_interp_sched.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cic_sched_pkg.sv
// rtl/cic_sched_pkg.sv - shared types and constants for the CIC interpolator TDM scheduler
package cic_sched_pkg;

  localparam int DW_DEF  = 16;
  localparam int NCH_MAX = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_RUN   = 2'd2,
    ST_FLUSH = 2'd3
  } sched_state_t;

  // Slot counter width; a 2-channel build still needs one bit.
  function automatic int slot_w(input int nch);
    return (nch <= 2) ? 1 : $clog2(nch);
  endfunction

endpackage

// File: rtl/cic_sched_fifo2.sv
// rtl/cic_sched_fifo2.sv - 2-entry per-channel sample buffer with synchronous clear
module cic_sched_fifo2
  import cic_sched_pkg::*;
#(
  parameter int DW = DW_DEF
) (
  input  logic          clk_7p68MHz,
  input  logic          reset,
  input  logic          clr,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] wdata,
  output logic          full,
  output logic          empty,
  output logic [DW-1:0] head
);

  logic [DW-1:0] mem [2];
  logic          rd_ptr;
  logic          wr_ptr;
  logic [1:0]    count;
  logic          do_push;
  logic          do_pop;

  assign do_push = push && (count != 2'd2);
  assign do_pop  = pop && (count != 2'd0);

  always_ff @(posedge clk_7p68MHz) begin
    if (!reset || clr) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) wr_ptr <= ~wr_ptr;
      if (do_pop)  rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  // Storage needs no reset: head is only consumed while count is non-zero.
  always_ff @(posedge clk_7p68MHz) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == 2'd2);
  assign empty = (count == 2'd0);

endmodule

// File: rtl/cic_interp_sched.sv
// rtl/cic_interp_sched.sv - round-robin TDM scheduler feeding a shared 4x CIC interpolator
// Optional SCHED_UFCNT_EN adds per-channel 8-bit saturating underflow counters on port ufcnt.
module cic_interp_sched
  import cic_sched_pkg::*;
#(
  parameter int NCH       = 4,
  parameter int DW        = DW_DEF,
  parameter int PRIME_TO  = 64,
  parameter int FLUSH_LEN = 8
) (
  input  logic              clk_7p68MHz,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic [NCH-1:0]    ch_en,
  input  logic [NCH*DW-1:0] in_data,
  input  logic [NCH-1:0]    in_valid,
  output logic [NCH-1:0]    in_ready,
  output logic [DW-1:0]     out_data,
  output logic [2:0]        out_ch,
  output logic              out_valid,
  output logic              out_sof,
  output logic              busy,
  output logic [NCH-1:0]    underflow
`ifdef SCHED_UFCNT_EN
  ,
  output logic [NCH*8-1:0]  ufcnt
`endif
);

  localparam int             SW         = slot_w(NCH);
  localparam logic [SW-1:0]  SLOT_LAST  = SW'(NCH - 1);
  localparam logic [15:0]    PRIME_LAST = 16'(PRIME_TO - 1);
  localparam logic [7:0]     FLUSH_LAST = 8'(FLUSH_LEN - 1);

  if (NCH < 2 || NCH > NCH_MAX) begin : g_nch_range
    $error("cic_interp_sched: NCH out of range");
  end

  sched_state_t  state;
  sched_state_t  state_nx;
  logic [SW-1:0] slot;
  logic [NCH-1:0] en_q;
  logic          stop_pend;
  logic [15:0]   prime_cnt;
  logic [7:0]    flush_cnt;

  logic [NCH-1:0] full;
  logic [NCH-1:0] empty;
  logic [NCH-1:0] push;
  logic [NCH-1:0] pop;
  logic [DW-1:0]  head [NCH];

  logic           accepting;
  logic           all_ready;
  logic           go_prime;
  logic           clr_buf;
  logic           emit;
  logic           sel_en;
  logic           sel_empty;
  logic [DW-1:0]  sel_head;
  logic [NCH-1:0] uf_vec;

  assign accepting = (state == ST_PRIME) || (state == ST_RUN);
  assign in_ready  = en_q & ~full & {NCH{accepting}};
  assign push      = in_valid & in_ready;
  assign all_ready = &(~empty | ~en_q);
  assign go_prime  = (state == ST_IDLE) && start && (|ch_en);
  assign clr_buf   = (state_nx == ST_IDLE);
  assign emit      = (state == ST_RUN) || (state == ST_FLUSH);
  assign busy      = (state != ST_IDLE);

  for (genvar k = 0; k < NCH; k++) begin : g_buf
    assign pop[k] = (state == ST_RUN) && (slot == SW'(k)) && en_q[k] && !empty[k];

    cic_sched_fifo2 #(.DW(DW)) u_fifo (
      .clk_7p68MHz (clk_7p68MHz),
      .reset       (reset),
      .clr         (clr_buf),
      .push        (push[k]),
      .pop         (pop[k]),
      .wdata       (in_data[k*DW +: DW]),
      .full        (full[k]),
      .empty       (empty[k]),
      .head        (head[k])
    );
  end

  always_comb begin
    sel_en    = 1'b0;
    sel_empty = 1'b1;
    sel_head  = '0;
    uf_vec    = '0;
    for (int k = 0; k < NCH; k++) begin
      if (slot == SW'(k)) begin
        sel_en    = en_q[k];
        sel_empty = empty[k];
        sel_head  = head[k];
        uf_vec[k] = (state == ST_RUN) && en_q[k] && empty[k];
      end
    end
  end

  always_ff @(posedge clk_7p68MHz) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: begin
        if (go_prime) state_nx = ST_PRIME;
      end
      ST_PRIME: begin
        if (stop)                                       state_nx = ST_IDLE;
        else if (all_ready || prime_cnt == PRIME_LAST)  state_nx = ST_RUN;
      end
      ST_RUN: begin
        // A stop only takes effect once the current frame has been emitted.
        if (slot == SLOT_LAST && (stop || stop_pend)) state_nx = ST_FLUSH;
      end
      ST_FLUSH: begin
        if (slot == SLOT_LAST && flush_cnt == FLUSH_LAST) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_7p68MHz) begin
    if (!reset) begin
      slot      <= '0;
      en_q      <= '0;
      stop_pend <= 1'b0;
      prime_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (go_prime) en_q <= ch_en;
      prime_cnt <= (state == ST_PRIME) ? prime_cnt + 16'd1 : 16'd0;
      if (emit) slot <= (slot == SLOT_LAST) ? '0 : slot + SW'(1);
      else      slot <= '0;
      stop_pend <= (state == ST_RUN) && (state_nx == ST_RUN) && (stop_pend || stop);
      if (state != ST_FLUSH)      flush_cnt <= '0;
      else if (slot == SLOT_LAST) flush_cnt <= flush_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk_7p68MHz) begin
    if (!reset) begin
      out_valid <= 1'b0;
      out_ch    <= 3'd0;
      out_sof   <= 1'b0;
      out_data  <= '0;
      underflow <= '0;
    end else begin
      out_valid <= emit;
      out_ch    <= emit ? 3'(slot) : 3'd0;
      out_sof   <= emit && (slot == '0);
      out_data  <= ((state == ST_RUN) && sel_en && !sel_empty) ? sel_head : '0;
      if (go_prime) underflow <= '0;
      else          underflow <= underflow | uf_vec;
    end
  end

`ifdef SCHED_UFCNT_EN
  for (genvar k = 0; k < NCH; k++) begin : g_ufcnt
    logic [7:0] cnt;
    always_ff @(posedge clk_7p68MHz) begin
      if (!reset || go_prime)              cnt <= 8'd0;
      else if (uf_vec[k] && cnt != 8'hFF)  cnt <= cnt + 8'd1;
    end
    assign ufcnt[k*8 +: 8] = cnt;
  end
`endif

endmodule

// File: tb/tb_cic_interp_sched.sv
// tb/tb_cic_interp_sched.sv - directed and randomized bench for cic_interp_sched against a queue model
module tb_cic_interp_sched;

  localparam int NCH = 4;
  localparam int DW  = 16;

  logic              clk_7p68MHz = 1'b0;
  logic              reset, start, stop;
  logic [NCH-1:0]    ch_en, in_valid, in_ready, underflow;
  logic [NCH*DW-1:0] in_data;
  logic [DW-1:0]     out_data;
  logic [2:0]        out_ch;
  logic              out_valid, out_sof, busy;
`ifdef SCHED_UFCNT_EN
  logic [NCH*8-1:0]  ufcnt;
`endif

  cic_interp_sched #(.NCH(NCH), .DW(DW), .PRIME_TO(64), .FLUSH_LEN(8)) dut (
    .clk_7p68MHz (clk_7p68MHz),
    .reset       (reset),
    .start       (start),
    .stop        (stop),
    .ch_en       (ch_en),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .out_data    (out_data),
    .out_ch      (out_ch),
    .out_valid   (out_valid),
    .out_sof     (out_sof),
    .busy        (busy),
    .underflow   (underflow)
`ifdef SCHED_UFCNT_EN
    ,
    .ufcnt       (ufcnt)
`endif
  );

  always #5 clk_7p68MHz = ~clk_7p68MHz;

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_on   = 1'b0;

  // Model: 0 idle, 1 prime, 2 run, 3 flush; buffers are plain queues.
  int             m_state, m_slot, m_pcnt, m_frames;
  bit             m_stop_pend;
  bit [NCH-1:0]   m_en;
  logic [DW-1:0]  m_q [NCH][$];
  bit             e_valid, e_sof;
  logic [DW-1:0]  e_data;
  int             e_ch;
  bit [NCH-1:0]   e_uf;
  int             e_ufc [NCH];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [NCH-1:0] m_ready();
    logic [NCH-1:0] r;
    for (int k = 0; k < NCH; k++)
      r[k] = m_en[k] && (m_q[k].size() < 2) && (m_state == 1 || m_state == 2);
    return r;
  endfunction

  task automatic m_go_idle();
    m_state = 0;
    m_slot  = 0;
    for (int k = 0; k < NCH; k++) m_q[k].delete();
  endtask

  task automatic model_step();
    logic [NCH-1:0] rdy;
    bit allne;
    if (!reset) begin
      m_go_idle();
      m_pcnt = 0; m_frames = 0; m_stop_pend = 0; m_en = '0;
      e_valid = 0; e_data = '0; e_ch = 0; e_sof = 0; e_uf = '0;
      for (int k = 0; k < NCH; k++) e_ufc[k] = 0;
      return;
    end
    rdy   = m_ready();
    allne = 1;
    for (int k = 0; k < NCH; k++) if (m_en[k] && m_q[k].size() == 0) allne = 0;
    e_valid = 0; e_data = '0; e_ch = 0; e_sof = 0;
    if (m_state >= 2) begin
      e_valid = 1; e_ch = m_slot; e_sof = (m_slot == 0);
      if (m_state == 2 && m_en[m_slot]) begin
        if (m_q[m_slot].size() > 0) e_data = m_q[m_slot].pop_front();
        else begin
          e_uf[m_slot] = 1;
          if (e_ufc[m_slot] < 255) e_ufc[m_slot]++;
        end
      end
    end
    for (int k = 0; k < NCH; k++)
      if (in_valid[k] && rdy[k]) m_q[k].push_back(in_data[k*DW +: DW]);
    case (m_state)
      0: if (start && ch_en != 0) begin
        m_state = 1; m_en = ch_en; m_pcnt = 0; e_uf = '0;
        for (int k = 0; k < NCH; k++) e_ufc[k] = 0;
      end
      1: begin
        if (stop) m_go_idle();
        else if (allne || m_pcnt == 63) begin m_state = 2; m_slot = 0; end
        else m_pcnt++;
      end
      2: begin
        if (stop) m_stop_pend = 1;
        if (m_slot == NCH - 1 && m_stop_pend) begin m_state = 3; m_frames = 0; m_stop_pend = 0; end
        m_slot = (m_slot + 1) % NCH;
      end
      default: begin
        if (m_slot == NCH - 1) begin
          if (m_frames == 7) m_go_idle();
          else m_frames++;
        end
        m_slot = (m_slot + 1) % NCH;
      end
    endcase
  endtask

  always @(negedge clk_7p68MHz) begin
    if (cmp_on) begin
      check("out_valid", out_valid, e_valid);
      check("out_data", out_data, e_data);
      check("out_ch", out_ch, e_ch);
      check("out_sof", out_sof, e_sof);
      check("busy", busy, m_state != 0);
      check("in_ready", in_ready, m_ready());
      check("underflow", underflow, e_uf);
`ifdef SCHED_UFCNT_EN
      for (int k = 0; k < NCH; k++) check("ufcnt", ufcnt[k*8 +: 8], e_ufc[k]);
`endif
    end
  end

  task automatic cyc();
    @(posedge clk_7p68MHz);
    #1;
    model_step();
  endtask

  task automatic pulse_start();
    start = 1'b1; cyc(); start = 1'b0;
  endtask

  task automatic stop_and_idle(input int budget);
    int n = 0;
    stop = 1'b1; cyc(); stop = 1'b0;
    while (busy && n < budget) begin cyc(); n++; end
    check("idle_timeout", busy, 1'b0);
  endtask

  task automatic set_const_data();
    for (int k = 0; k < NCH; k++) in_data[k*DW +: DW] = 16'h1000 + 16'(k);
  endtask

  logic [DW-1:0] got [$];
  int  exp_ch, n, run_len, zeros, found;
  bit  seen13;
  logic [DW-1:0] first_d, second_d;

  initial begin
    reset = 1'b0; start = 1'b0; stop = 1'b0; ch_en = '0; in_valid = '0; in_data = '0;
    cyc(); cyc();
    cmp_on = 1'b1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_in_ready", in_ready, 4'b0000);
    reset = 1'b1;

    // Reset in RUN with buffers holding data.
    ch_en = 4'b1111; set_const_data(); pulse_start();
    in_valid = 4'b1111;
    for (int i = 0; i < 10; i++) cyc();
    reset = 1'b0; cyc(); reset = 1'b1; in_valid = '0;
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_in_ready", in_ready, 4'b0000);
    check("midrst_underflow", underflow, 4'b0000);

    // All channels, one push per channel every 4 cycles.
    ch_en = 4'b1111; set_const_data(); pulse_start();
    exp_ch = -1;
    for (int i = 0; i < 48; i++) begin
      in_valid = (i % 4 == 0) ? 4'b1111 : 4'b0000;
      cyc();
      if (out_valid) begin
        exp_ch = (exp_ch + 1) % NCH;
        check("t2_ch", out_ch, exp_ch);
        check("t2_sof", out_sof, exp_ch == 0);
        check("t2_data", out_data, 16'h1000 + 16'(exp_ch));
      end
    end
    check("t2_underflow", underflow, 4'b0000);

    // Stop seen while slot 2 is being decided.
    found = 0;
    for (int i = 0; i < 8 && !found; i++) begin
      if (out_valid && out_ch == 3'd1) found = 1;
      else begin in_valid = '0; cyc(); end
    end
    check("t5_sync", found, 1);
    stop = 1'b1; in_valid = '0; cyc(); stop = 1'b0;
    run_len = 0; zeros = 0; first_d = '0; second_d = '0;
    for (int i = 0; i < 60 && out_valid; i++) begin
      if (run_len == 0) first_d = out_data;
      if (run_len == 1) second_d = out_data;
      if (run_len >= 2 && out_data == '0) zeros++;
      run_len++;
      cyc();
    end
    check("t5_slot2", first_d, 16'h1002);
    check("t5_slot3", second_d, 16'h1003);
    check("t5_len", run_len, 34);
    check("t5_zeros", zeros, 32);
    check("t5_busy", busy, 1'b0);

    // Channels 1 and 3 disabled while everyone pushes.
    ch_en = 4'b0101; pulse_start(); seen13 = 0;
    for (int i = 0; i < 60; i++) begin
      in_valid = 4'b1111; in_data = {$urandom, $urandom};
      cyc();
      seen13 |= in_ready[1] | in_ready[3];
      if (out_valid && out_ch[0]) check("t3_dis_data", out_data, 16'h0000);
    end
    check("t3_ready13", seen13, 1'b0);
    check("t3_uf13", {underflow[3], underflow[1]}, 2'b00);
    in_valid = '0; stop_and_idle(80);

    // Channel 0 starved: PRIME times out, every slot-0 output underflows.
    ch_en = 4'b0001; in_valid = '0; pulse_start();
    n = 0;
    for (int i = 0; i < 100 && !out_valid; i++) begin cyc(); n++; end
    check("t4_prime_len", n, 65);
    for (int i = 0; i < 1100; i++) begin
      cyc();
      if (out_valid && out_sof) check("t4_slot0_data", out_data, 16'h0000);
    end
    check("t4_uf0", underflow[0], 1'b1);
`ifdef SCHED_UFCNT_EN
    check("t4_ufcnt_sat", ufcnt[7:0], 8'hFF);
`endif
    stop_and_idle(80);

    // Full buffer, then simultaneous push and pop on channel 0.
    ch_en = 4'b0001; pulse_start(); got.delete();
    in_valid = 4'b0001; in_data = '0; in_data[15:0] = 16'hA5A5; cyc();
    in_data[15:0] = 16'h5A5A; cyc();
    check("t6_full_ready", in_ready[0], 1'b0);
    in_valid = '0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      if (out_valid && out_sof) got.push_back(out_data);
    end
    in_valid = 4'b0001; in_data[15:0] = 16'h3C3C; cyc();
    if (out_valid && out_sof) got.push_back(out_data);
    in_valid = '0;
    for (int i = 0; i < 8; i++) begin
      cyc();
      if (out_valid && out_sof) got.push_back(out_data);
    end
    check("t6_count", got.size() >= 3, 1'b1);
    if (got.size() >= 3) begin
      check("t6_first", got[0], 16'hA5A5);
      check("t6_second", got[1], 16'h5A5A);
      check("t6_third", got[2], 16'h3C3C);
    end
    stop_and_idle(80);

    // Random traffic, control pulses and occasional resets.
    for (int blk = 0; blk < 8; blk++) begin
      int dens = $urandom_range(1, 8);
      for (int i = 0; i < 500; i++) begin
        reset = ($urandom_range(0, 599) != 0);
        start = ($urandom_range(0, 29) == 0);
        stop  = ($urandom_range(0, 59) == 0);
        ch_en = 4'($urandom_range(0, 15));
        for (int k = 0; k < NCH; k++) in_valid[k] = ($urandom_range(0, 8) < dens);
        in_data = {$urandom, $urandom};
        cyc();
      end
    end
    reset = 1'b1; start = 1'b0; stop = 1'b0; in_valid = '0;
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
